// File: rtl/wb_stage_if.sv
// EX/WB buffer outputs consumed by the writeback stage, plus the stage's own results.
// slave is the stage's view; master is the driver/observer view.
interface wb_stage_if #(
    parameter int unsigned CNT_W = 32
);
    logic             valid_wb;
    logic [1:0]       writeBackControl_wb;
    logic             regWrt_wb;
    logic             branchZero_wb;
    logic             branchNeg_wb;
    logic             jump_wb;
    logic             jumpMem_wb;
    logic [31:0]      pc_plus_y_wb;
    logic [31:0]      xrs_wb;
    logic [31:0]      readData_wb;
    logic [31:0]      aluResult_wb;
    logic             z_wb;
    logic             n_wb;
    logic [5:0]       rd_wb;

    logic             rf_we;
    logic [5:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             flush;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] squashed_cnt;

    modport slave (
        input  valid_wb, writeBackControl_wb, regWrt_wb, branchZero_wb, branchNeg_wb,
               jump_wb, jumpMem_wb, pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb,
               z_wb, n_wb, rd_wb,
        output rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, flush,
               retired_cnt, squashed_cnt
    );

    modport master (
        output valid_wb, writeBackControl_wb, regWrt_wb, branchZero_wb, branchNeg_wb,
               jump_wb, jumpMem_wb, pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb,
               z_wb, n_wb, rd_wb,
        input  rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, flush,
               retired_cnt, squashed_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback / branch-resolve stage: register-file write port, PC redirect,
// post-branch flush FSM and retired/squashed instruction counters.
module wb_stage #(
    parameter int unsigned FLUSH_DEPTH = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    wb_stage_if.slave  bus
);
    localparam int unsigned CntBits = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e             state_q, state_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [5:0]         rf_waddr_q, rf_waddr_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        target_q, target_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   squashed_q, squashed_d;

    logic live;
    logic squash;
    logic taken;

    always_comb begin
        live   = bus.valid_wb && (state_q == StRun);
        squash = bus.valid_wb && (state_q == StFlush);
        taken  = live && (bus.jumpMem_wb || bus.jump_wb ||
                          (bus.branchZero_wb && bus.z_wb) ||
                          (bus.branchNeg_wb && bus.n_wb));

        rf_we_d    = live && bus.regWrt_wb;
        rf_waddr_d = bus.rd_wb;
        unique case (bus.writeBackControl_wb)
            2'b01:   rf_wdata_d = bus.readData_wb;
            2'b10:   rf_wdata_d = bus.pc_plus_y_wb;
            default: rf_wdata_d = bus.aluResult_wb;
        endcase

        redirect_d = taken;
        target_d   = target_q;
        if (taken) begin
            target_d = bus.jumpMem_wb ? bus.readData_wb : bus.xrs_wb;
        end

        retired_d  = retired_q + CNT_W'(live);
        squashed_d = squashed_q + CNT_W'(squash);

        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (taken && (FLUSH_DEPTH > 0)) begin
                    state_d = StFlush;
                    cnt_d   = CntBits'(FLUSH_DEPTH);
                end
            end
            StFlush: begin
                // Counts down the squash window; taken conditions are ignored here.
                cnt_d = cnt_q - CntBits'(1);
                if (cnt_q == CntBits'(1)) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
            retired_q  <= '0;
            squashed_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            retired_q  <= retired_d;
            squashed_q <= squashed_d;
        end
    end

    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.pc_redirect  = redirect_q;
    assign bus.pc_target    = target_q;
    assign bus.flush        = (state_q == StFlush);
    assign bus.retired_cnt  = retired_q;
    assign bus.squashed_cnt = squashed_q;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage: a per-cycle behavioural model plus directed scenarios
// with hand-computed expectations.
module tb_wb_stage;
    localparam int unsigned D     = 3;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    wb_stage_if #(.CNT_W(CNT_W)) bus ();

    wb_stage #(.FLUSH_DEPTH(D), .CNT_W(CNT_W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: squash window as a plain countdown of remaining cycles.
    logic        m_we, m_redir;
    logic [5:0]  m_waddr;
    logic [31:0] m_wdata, m_target;
    int          m_left;
    int unsigned m_ret, m_sq;

    initial begin
        logic r, v, rw, bz, bn, j, jm, z, n;
        logic [1:0] wbc;
        logic [31:0] ppy, xrs, rdd, alu;
        logic [5:0] rd;
        logic in_run, tk;
        forever begin
            @(posedge clk);
            r = rst_n; v = bus.valid_wb; rw = bus.regWrt_wb; bz = bus.branchZero_wb;
            bn = bus.branchNeg_wb; j = bus.jump_wb; jm = bus.jumpMem_wb; z = bus.z_wb;
            n = bus.n_wb; wbc = bus.writeBackControl_wb; ppy = bus.pc_plus_y_wb;
            xrs = bus.xrs_wb; rdd = bus.readData_wb; alu = bus.aluResult_wb; rd = bus.rd_wb;
            #1;
            if (!r) begin
                m_we = 0; m_redir = 0; m_waddr = 0; m_wdata = 0; m_target = 0;
                m_left = 0; m_ret = 0; m_sq = 0;
            end else begin
                in_run = (m_left == 0);
                tk = v && in_run && (jm || j || (bz && z) || (bn && n));
                if (v && in_run) m_ret++;
                if (v && !in_run) m_sq++;
                m_we = v && in_run && rw;
                m_waddr = rd;
                m_wdata = (wbc == 2'b01) ? rdd : (wbc == 2'b10) ? ppy : alu;
                m_redir = tk;
                if (tk) m_target = jm ? rdd : xrs;
                if (m_left > 0) m_left--;
                if (tk) m_left = D;
            end
            chk("rf_we", 32'(bus.rf_we), 32'(m_we));
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
            chk("rf_wdata", bus.rf_wdata, m_wdata);
            chk("pc_redirect", 32'(bus.pc_redirect), 32'(m_redir));
            chk("pc_target", bus.pc_target, m_target);
            chk("flush", 32'(bus.flush), 32'(m_left > 0));
            chk("retired_cnt", bus.retired_cnt, m_ret);
            chk("squashed_cnt", bus.squashed_cnt, m_sq);
        end
    end

    task automatic idle();
        bus.valid_wb = 0; bus.writeBackControl_wb = 0; bus.regWrt_wb = 0;
        bus.branchZero_wb = 0; bus.branchNeg_wb = 0; bus.jump_wb = 0; bus.jumpMem_wb = 0;
        bus.pc_plus_y_wb = 0; bus.xrs_wb = 0; bus.readData_wb = 0; bus.aluResult_wb = 0;
        bus.z_wb = 0; bus.n_wb = 0; bus.rd_wb = 0;
    endtask

    task automatic randomize_inputs(input int branch_odds);
        bus.valid_wb = ($urandom_range(9) != 0);
        bus.writeBackControl_wb = 2'($urandom_range(3));
        bus.regWrt_wb = 1'($urandom_range(1));
        bus.branchZero_wb = ($urandom_range(branch_odds) == 0);
        bus.branchNeg_wb = ($urandom_range(branch_odds) == 0);
        bus.jump_wb = ($urandom_range(branch_odds) == 0);
        bus.jumpMem_wb = ($urandom_range(branch_odds) == 0);
        bus.pc_plus_y_wb = $urandom; bus.xrs_wb = $urandom;
        bus.readData_wb = $urandom; bus.aluResult_wb = $urandom;
        bus.z_wb = 1'($urandom_range(1)); bus.n_wb = 1'($urandom_range(1));
        bus.rd_wb = 6'($urandom_range(63));
    endtask

    // Advance one cycle; outputs of that edge are stable on return.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0; tick(); rst_n = 1;
    endtask

    task automatic alu_op(input logic [1:0] wbc, input logic [5:0] rd);
        idle();
        bus.valid_wb = 1; bus.regWrt_wb = 1; bus.writeBackControl_wb = wbc;
        bus.aluResult_wb = 32'h1234; bus.readData_wb = 32'h5678;
        bus.pc_plus_y_wb = 32'h9abc; bus.rd_wb = rd;
    endtask

    initial begin
        rst_n = 0;
        idle();
        // 1: reset with random inputs
        @(negedge clk);
        randomize_inputs(1); tick(); randomize_inputs(1); tick();
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        chk("rst_target", bus.pc_target, 0);
        chk("rst_retired", bus.retired_cnt, 0);
        rst_n = 1; idle(); tick();
        chk("rel_flush", 32'(bus.flush), 0);
        chk("rel_squashed", bus.squashed_cnt, 0);

        // 2: writeback mux
        alu_op(2'b00, 6'd5); tick();
        chk("alu_we", 32'(bus.rf_we), 1);
        chk("alu_addr", 32'(bus.rf_waddr), 5);
        chk("alu_data", bus.rf_wdata, 32'h1234);
        alu_op(2'b01, 6'd6); tick(); chk("rdata_data", bus.rf_wdata, 32'h5678);
        alu_op(2'b10, 6'd7); tick(); chk("ppy_data", bus.rf_wdata, 32'h9abc);
        alu_op(2'b11, 6'd8); tick(); chk("wbc11_data", bus.rf_wdata, 32'h1234);

        // 3: BRZ taken, then squash window
        do_reset();
        idle(); bus.valid_wb = 1; bus.branchZero_wb = 1; bus.z_wb = 1; bus.xrs_wb = 32'h40;
        tick();
        chk("brz_redir", 32'(bus.pc_redirect), 1);
        chk("brz_target", bus.pc_target, 32'h40);
        for (int i = 0; i < 3; i++) begin
            alu_op(2'b00, 6'd9); tick();
            chk("brz_flush", 32'(bus.flush), (i < 2) ? 1 : 0);
            chk("brz_nowrite", 32'(bus.rf_we), 0);
            chk("brz_redir_pulse", 32'(bus.pc_redirect), 0);
        end
        chk("brz_squashed", bus.squashed_cnt, 3);
        idle(); bus.valid_wb = 1; bus.branchZero_wb = 1; bus.z_wb = 0; tick();
        chk("brz_nt_redir", 32'(bus.pc_redirect), 0);

        // 4: JM beats J; BRN inside the flush is ignored
        idle(); bus.valid_wb = 1; bus.jumpMem_wb = 1; bus.jump_wb = 1;
        bus.readData_wb = 32'h80; bus.xrs_wb = 32'h40; tick();
        chk("jm_target", bus.pc_target, 32'h80);
        idle(); bus.valid_wb = 1; bus.branchNeg_wb = 1; bus.n_wb = 1; bus.xrs_wb = 32'hC0;
        tick();
        chk("brn_ignored", 32'(bus.pc_redirect), 0);
        chk("brn_target_held", bus.pc_target, 32'h80);
        idle(); tick(); tick();
        chk("jm_flush_done", 32'(bus.flush), 0);

        // 5: reset on second flush cycle
        idle(); bus.valid_wb = 1; bus.jump_wb = 1; bus.xrs_wb = 32'h100; tick();
        idle(); tick();
        rst_n = 0; tick(); rst_n = 1;
        chk("midflush_rst", 32'(bus.flush), 0);
        alu_op(2'b00, 6'd3); tick();
        chk("post_rst_we", 32'(bus.rf_we), 1);
        chk("post_rst_retired", bus.retired_cnt, 1);
        chk("post_rst_squashed", bus.squashed_cnt, 0);

        // 6: 10 ALU ops, 2 bubbles, one J, then D squashed ops
        do_reset();
        for (int i = 0; i < 10; i++) begin alu_op(2'b00, 6'(i)); tick(); end
        idle(); tick(); tick();
        idle(); bus.valid_wb = 1; bus.jump_wb = 1; bus.xrs_wb = 32'h200; tick();
        for (int i = 0; i < int'(D); i++) begin alu_op(2'b00, 6'd1); tick(); end
        idle(); tick();
        chk("mix_retired", bus.retired_cnt, 11);
        chk("mix_squashed", bus.squashed_cnt, D);

        // Random phase with occasional resets
        for (int i = 0; i < 600; i++) begin
            randomize_inputs(6);
            rst_n = ($urandom_range(59) != 0);
            tick();
        end
        rst_n = 1; idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
